// File: rtl/alu_src_sel_pipe.sv
// Pipelined ALU source-B operand selector: picks one of NUM_IN operands,
// applies immediate extension and queues the result in a 2-entry buffer.
module alu_src_sel_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2,
  parameter int IMM_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic [1:0]              ext_mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  input  logic                    err_clr
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] head, tail, head_next, tail_next;
  logic [WIDTH-1:0] raw, sext, res;
  logic             illegal, push, pop;

  // Out-of-range selects yield a zero operand rather than an X or alias
  always_comb begin
    raw = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) raw = in_data[k*WIDTH +: WIDTH];
    end
  end

  assign illegal = (32'(sel) >= NUM_IN);
  assign sext    = {{(WIDTH-IMM_W){raw[IMM_W-1]}}, raw[IMM_W-1:0]};

  always_comb begin
    res = raw;
    case (ext_mode)
      2'b00:   res = raw;
      2'b01:   res = sext;
      2'b10:   res = {{(WIDTH-IMM_W){1'b0}}, raw[IMM_W-1:0]};
      default: res = sext << 2;
    endcase
  end

  // Ready depends only on registered occupancy, so no out_ready -> in_ready path
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign out_data  = head;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_next = state;
    head_next  = head;
    tail_next  = tail;
    case (state)
      EMPTY: begin
        if (push) begin
          head_next  = res;
          state_next = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_next = res;
        end else if (push) begin
          tail_next  = res;
          state_next = FULL;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          head_next  = tail;
          state_next = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // A set in the same cycle as err_clr takes priority over the clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= EMPTY;
      head    <= '0;
      tail    <= '0;
      sel_err <= 1'b0;
    end else begin
      state <= state_next;
      head  <= head_next;
      tail  <= tail_next;
      if (push && illegal)
        sel_err <= 1'b1;
      else if (err_clr)
        sel_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_src_sel_pipe.sv
// Scoreboard bench for alu_src_sel_pipe: a default-parameter instance and a
// NUM_IN=3 instance run in lockstep against a queue-based reference model.
module tb_alu_src_sel_pipe;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [127:0] in_data = '0;
  logic [1:0]   sel = '0;
  logic [1:0]   ext_mode = '0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         err_clr = 1'b0;

  logic        in_ready4, out_valid4, sel_err4;
  logic [31:0] out_data4;
  logic        in_ready3, out_valid3, sel_err3;
  logic [31:0] out_data3;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] q4[$];
  logic [31:0] q3[$];
  int          mcount = 0;
  logic        merr4 = 1'b0;
  logic        merr3 = 1'b0;

  alu_src_sel_pipe dut (
    .clk(clk), .reset(reset), .in_data(in_data), .sel(sel), .ext_mode(ext_mode),
    .in_valid(in_valid), .in_ready(in_ready4), .out_data(out_data4),
    .out_valid(out_valid4), .out_ready(out_ready), .sel_err(sel_err4),
    .err_clr(err_clr)
  );

  alu_src_sel_pipe #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .IMM_W(16)) dut3 (
    .clk(clk), .reset(reset), .in_data(in_data[95:0]), .sel(sel), .ext_mode(ext_mode),
    .in_valid(in_valid), .in_ready(in_ready3), .out_data(out_data3),
    .out_valid(out_valid3), .out_ready(out_ready), .sel_err(sel_err3),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] modelResult(input logic [127:0] ops, input logic [1:0] s,
                                              input logic [1:0] m, input int n);
    logic [31:0] raw, sx;
    int idx;
    idx = int'(s);
    raw = (idx < n) ? ops[idx*32 +: 32] : 32'h0;
    sx  = {{16{raw[15]}}, raw[15:0]};
    case (m)
      2'b00:   return raw;
      2'b01:   return sx;
      2'b10:   return {16'h0, raw[15:0]};
      default: return sx << 2;
    endcase
  endfunction

  // Drives one cycle at the falling edge, checks outputs, then updates the model
  task automatic applyStimulus(input logic v, input logic [1:0] s, input logic [1:0] m,
                               input logic ordy, input logic clr);
    bit push, pop;
    in_valid  = v;
    sel       = s;
    ext_mode  = m;
    out_ready = ordy;
    err_clr   = clr;
    #1;
    checkOutput("in_ready4", 32'(in_ready4), 32'(mcount != 2));
    checkOutput("in_ready3", 32'(in_ready3), 32'(mcount != 2));
    checkOutput("out_valid4", 32'(out_valid4), 32'(mcount != 0));
    checkOutput("out_valid3", 32'(out_valid3), 32'(mcount != 0));
    checkOutput("sel_err4", 32'(sel_err4), 32'(merr4));
    checkOutput("sel_err3", 32'(sel_err3), 32'(merr3));
    if (mcount > 0) begin
      checkOutput("out_data4", out_data4, q4[0]);
      checkOutput("out_data3", out_data3, q3[0]);
    end
    push = v && (mcount != 2);
    pop  = (mcount != 0) && ordy;
    if (pop) begin
      void'(q4.pop_front());
      void'(q3.pop_front());
      mcount--;
    end
    if (push) begin
      q4.push_back(modelResult(in_data, s, m, 4));
      q3.push_back(modelResult(in_data, s, m, 3));
      mcount++;
    end
    if (push && int'(s) >= 4) merr4 = 1'b1;
    else if (clr)             merr4 = 1'b0;
    if (push && int'(s) >= 3) merr3 = 1'b1;
    else if (clr)             merr3 = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_valid4"}, 32'(out_valid4), 32'h0);
    checkOutput({tag, "_valid3"}, 32'(out_valid3), 32'h0);
    checkOutput({tag, "_data4"}, out_data4, 32'h0);
    checkOutput({tag, "_data3"}, out_data3, 32'h0);
    checkOutput({tag, "_err4"}, 32'(sel_err4), 32'h0);
    checkOutput({tag, "_err3"}, 32'(sel_err3), 32'h0);
    checkOutput({tag, "_rdy4"}, 32'(in_ready4), 32'h1);
    checkOutput({tag, "_rdy3"}, 32'(in_ready3), 32'h1);
  endtask

  initial begin
    #1 reset = 1'b1;
    #1 checkIdle("reset");
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] pass-through");
    in_data[95:64] = 32'hDEAD_BEEF;
    applyStimulus(1'b1, 2'd2, 2'b00, 1'b1, 1'b0);
    checkOutput("t1_direct", out_data4, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 2'd2, 2'b00, 1'b1, 1'b0);

    $display("[TB] extension modes");
    in_data[31:0] = 32'h0000_8004;
    applyStimulus(1'b1, 2'd0, 2'b01, 1'b1, 1'b0);
    checkOutput("t2_sext", out_data4, 32'hFFFF_8004);
    applyStimulus(1'b1, 2'd0, 2'b10, 1'b1, 1'b0);
    checkOutput("t2_zext", out_data4, 32'h0000_8004);
    applyStimulus(1'b1, 2'd0, 2'b11, 1'b1, 1'b0);
    checkOutput("t2_shl", out_data4, 32'hFFFE_0010);
    applyStimulus(1'b0, 2'd0, 2'b00, 1'b1, 1'b0);

    $display("[TB] backpressure");
    in_data[63:32] = 32'hAAAA_0001;
    applyStimulus(1'b1, 2'd1, 2'b00, 1'b0, 1'b0);
    in_data[63:32] = 32'hBBBB_0002;
    applyStimulus(1'b1, 2'd1, 2'b00, 1'b0, 1'b0);
    in_data[63:32] = 32'hCCCC_0003;
    applyStimulus(1'b1, 2'd1, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'd1, 2'b00, 1'b0, 1'b0);
    checkOutput("t3_hold", out_data4, 32'hAAAA_0001);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'd1, 2'b00, 1'b1, 1'b0);

    $display("[TB] streaming");
    for (int k = 0; k < 8; k++) begin
      in_data[63:32] = 32'(k);
      applyStimulus(1'b1, 2'd1, 2'b00, 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 2'd1, 2'b00, 1'b1, 1'b0);

    $display("[TB] illegal select");
    in_data[127:96] = 32'h1234_9678;
    applyStimulus(1'b1, 2'd3, 2'b00, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'd3, 2'b01, 1'b1, 1'b1);
    in_data[63:32] = 32'h0000_7FFF;
    applyStimulus(1'b1, 2'd1, 2'b11, 1'b1, 1'b0);
    applyStimulus(1'b0, 2'd0, 2'b00, 1'b1, 1'b1);
    applyStimulus(1'b0, 2'd3, 2'b00, 1'b1, 1'b0);
    applyStimulus(1'b0, 2'd0, 2'b00, 1'b1, 1'b0);

    $display("[TB] async reset while full");
    in_data[95:64] = 32'h5555_AAAA;
    applyStimulus(1'b1, 2'd3, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd2, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'd2, 2'b00, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1 checkIdle("midreset");
    q4.delete();
    q3.delete();
    mcount = 0;
    merr4  = 1'b0;
    merr3  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    in_data[63:32] = 32'h0BAD_F00D;
    applyStimulus(1'b1, 2'd1, 2'b00, 1'b1, 1'b0);
    applyStimulus(1'b0, 2'd0, 2'b00, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
